si4463_cmd_seq: RTL and testbench

- Command sequencer for the Si4463 radio. It drives the 8-bit SPI master's CPU register port.
- Takes one command (opcode plus argument bytes) from the host side and sends it with NSEL held low across all bytes.
- Polls CTS with READ_CMD_BUFF (0x44) until the radio returns 0xFF, then reads back a fixed-length response.
- Sits between the radio driver logic and the SPI master; it is the only master of the SPI register port.

---
 rtl/si4463_cmd_seq_if.sv | 21 ++
 rtl/si4463_cmd_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_si4463_cmd_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/si4463_cmd_seq_if.sv
// rtl/si4463_cmd_seq_if.sv - SPI master CPU register port bundle for the Si4463 sequencer
interface si4463_cmd_seq_if;
   logic        spi_cs;
   logic [2:0]  spi_addr;
   logic [15:0] spi_wdata;
   logic        spi_wr_n;
   logic        spi_rd_n;
   logic [15:0] spi_rdata;
   logic        spi_rrdy;
   logic        spi_tmt;

   modport master (
      output spi_cs, spi_addr, spi_wdata, spi_wr_n, spi_rd_n,
      input  spi_rdata, spi_rrdy, spi_tmt
   );

   modport slave (
      input  spi_cs, spi_addr, spi_wdata, spi_wr_n, spi_rd_n,
      output spi_rdata, spi_rrdy, spi_tmt
   );
endinterface

// File: rtl/si4463_cmd_seq.sv
// rtl/si4463_cmd_seq.sv - Si4463 command send, CTS poll and response read over the SPI master register port
module si4463_cmd_seq #(
   parameter int MAX_LEN  = 16,
   parameter int POLL_MAX = 255,
   parameter int POLL_GAP = 64
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [$clog2(MAX_LEN+1)-1:0] tx_len,
   input  logic [$clog2(MAX_LEN+1)-1:0] rsp_len,
   input  logic [7:0]                   tx_data,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   output logic [7:0]                   rsp_data,
   output logic                         rsp_valid,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   si4463_cmd_seq_if.master             spi
);
   localparam int LW = $clog2(MAX_LEN+1);
   localparam int PW = $clog2(POLL_MAX+1);
   localparam int GW = $clog2(POLL_GAP+1);
   localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_MAX);
   localparam logic [GW-1:0] GAP_LAST    = GW'(POLL_GAP-1);
   localparam logic [2:0]    ADDR_RXD    = 3'd0;
   localparam logic [2:0]    ADDR_TXD    = 3'd1;
   localparam logic [2:0]    ADDR_CTL    = 3'd3;
   localparam logic [15:0]   CTL_SS_HOLD = 16'h0400;
   localparam logic [15:0]   CTL_SS_REL  = 16'h0000;

   typedef enum logic [3:0] {
      IDLE, SS_ON, TX_GET, TX_XFER, CMD_END, P_SS_ON, P_CMD,
      P_CTS, RSP, P_END, GAP, FIN_OK, FIN_ERR
   } state_t;

   // Bus access phases: two strobe cycles, then one idle cycle that reports completion
   typedef enum logic [1:0] {PH_IDLE, PH_A1, PH_A2, PH_DONE} ph_t;

   state_t          state, state_nx;
   logic [2:0]      step, step_nx;
   ph_t             ph;
   logic [7:0]      rx;
   logic            acc_go, acc_rd, acc_done;
   logic [2:0]      acc_addr;
   logic [15:0]     acc_wdata;
   logic [7:0]      xfer_byte, tx_byte;
   logic [LW-1:0]   tx_len_q, rsp_len_q, tx_cnt, rsp_cnt;
   logic [PW-1:0]   poll_cnt;
   logic [GW-1:0]   gap_cnt;
   logic            unused_rdata_hi;

   assign acc_done        = (ph == PH_DONE);
   assign rsp_data        = rx;
   assign unused_rdata_hi = ^spi.spi_rdata[15:8];

   // Bus access engine: drives one register read or write with registered strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph            <= PH_IDLE;
         spi.spi_cs    <= 1'b0;
         spi.spi_wr_n  <= 1'b1;
         spi.spi_rd_n  <= 1'b1;
         spi.spi_addr  <= 3'd0;
         spi.spi_wdata <= 16'h0000;
         rx            <= 8'h00;
      end else begin
         case (ph)
            PH_A1: ph <= PH_A2;
            PH_A2: begin
               ph           <= PH_DONE;
               spi.spi_cs   <= 1'b0;
               spi.spi_wr_n <= 1'b1;
               spi.spi_rd_n <= 1'b1;
               if (!spi.spi_rd_n) rx <= spi.spi_rdata[7:0];
            end
            default: ph <= PH_IDLE;
         endcase
         if (acc_go) begin
            ph            <= PH_A1;
            spi.spi_cs    <= 1'b1;
            spi.spi_wr_n  <= acc_rd;
            spi.spi_rd_n  <= !acc_rd;
            spi.spi_addr  <= acc_addr;
            spi.spi_wdata <= acc_wdata;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         step  <= 3'd0;
      end else begin
         state <= state_nx;
         step  <= step_nx;
      end
   end

   // Next state, bus requests and host-side outputs
   always_comb begin
      state_nx  = state;
      step_nx   = step;
      acc_go    = 1'b0;
      acc_rd    = 1'b0;
      acc_addr  = ADDR_TXD;
      acc_wdata = CTL_SS_REL;
      tx_ready  = 1'b0;
      rsp_valid = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      busy      = !(state == IDLE || state == FIN_OK || state == FIN_ERR);
      xfer_byte = (state == TX_XFER) ? tx_byte : (state == P_CMD) ? 8'h44 : 8'hFF;
      case (state)
         IDLE: if (start) state_nx = (tx_len == '0) ? FIN_ERR : SS_ON;
         SS_ON, P_SS_ON: begin
            if (step == 3'd0) begin
               acc_go    = 1'b1;
               acc_addr  = ADDR_CTL;
               acc_wdata = CTL_SS_HOLD;
               step_nx   = 3'd1;
            end else if (acc_done) begin
               step_nx  = 3'd0;
               state_nx = (state == SS_ON) ? TX_GET : P_CMD;
            end
         end
         TX_GET: begin
            tx_ready = 1'b1;
            if (tx_valid) state_nx = TX_XFER;
         end
         TX_XFER, P_CMD, P_CTS, RSP: begin
            case (step)
               3'd0: begin
                  acc_go    = 1'b1;
                  acc_wdata = {8'h00, xfer_byte};
                  step_nx   = 3'd1;
               end
               3'd1: if (acc_done) step_nx = 3'd2;
               3'd2: if (spi.spi_rrdy) begin
                  acc_go   = 1'b1;
                  acc_rd   = 1'b1;
                  acc_addr = ADDR_RXD;
                  step_nx  = 3'd3;
               end
               3'd3: if (acc_done) begin
                  step_nx = 3'd0;
                  case (state)
                     TX_XFER: state_nx = (tx_cnt + 1'b1 == tx_len_q) ? CMD_END : TX_GET;
                     P_CMD:   state_nx = P_CTS;
                     P_CTS: begin
                        if (rx == 8'hFF) state_nx = (rsp_len_q == '0) ? P_END : RSP;
                        else             step_nx  = 3'd4;
                     end
                     default: begin
                        rsp_valid = 1'b1;
                        if (rsp_cnt + 1'b1 == rsp_len_q) state_nx = P_END;
                     end
                  endcase
               end
               // Failed CTS: release SS once the shifter is empty
               3'd4: if (spi.spi_tmt) begin
                  acc_go   = 1'b1;
                  acc_addr = ADDR_CTL;
                  step_nx  = 3'd5;
               end
               default: if (acc_done) begin
                  step_nx  = 3'd0;
                  state_nx = (poll_cnt == POLL_LAST) ? FIN_ERR : GAP;
               end
            endcase
         end
         CMD_END, P_END: begin
            if (step == 3'd0) begin
               if (spi.spi_tmt) begin
                  acc_go   = 1'b1;
                  acc_addr = ADDR_CTL;
                  step_nx  = 3'd1;
               end
            end else if (acc_done) begin
               step_nx  = 3'd0;
               state_nx = (state == CMD_END) ? P_SS_ON : FIN_OK;
            end
         end
         GAP: if (gap_cnt == GAP_LAST) state_nx = P_SS_ON;
         FIN_OK: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         FIN_ERR: begin
            err      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command lengths, byte counters, poll count and inter-poll gap timer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_len_q  <= '0;
         rsp_len_q <= '0;
         tx_cnt    <= '0;
         rsp_cnt   <= '0;
         tx_byte   <= 8'h00;
         poll_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         if (state == IDLE && start) begin
            tx_len_q  <= tx_len;
            rsp_len_q <= rsp_len;
            tx_cnt    <= '0;
            rsp_cnt   <= '0;
         end
         if (state == TX_GET && tx_valid) tx_byte <= tx_data;
         if (state == TX_XFER && step == 3'd3 && acc_done) tx_cnt <= tx_cnt + 1'b1;
         if (rsp_valid) rsp_cnt <= rsp_cnt + 1'b1;
         if (state == CMD_END && step == 3'd1 && acc_done) poll_cnt <= PW'(1);
         if (state == GAP && gap_cnt == GAP_LAST) poll_cnt <= poll_cnt + 1'b1;
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      end
   end
endmodule

// File: tb/tb_si4463_cmd_seq.sv
// tb/tb_si4463_cmd_seq.sv - directed bench for si4463_cmd_seq with SPI master and radio model
`timescale 1ns/1ps
module tb_si4463_cmd_seq;
   localparam int POLL_MAX = 4;
   localparam int POLL_GAP = 8;

   logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [4:0] tx_len = 5'd0, rsp_len = 5'd0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, rsp_valid, busy, done, err;
   logic [7:0] rsp_data;

   si4463_cmd_seq_if bus();

   si4463_cmd_seq #(.MAX_LEN(16), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tx_len(tx_len), .rsp_len(rsp_len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rsp_data(rsp_data),
      .rsp_valid(rsp_valid), .busy(busy), .done(done), .err(err), .spi(bus.master)
   );

   always #10 clk = ~clk;

   int checks = 0, errors = 0;

   // SPI master and radio model state
   logic        ss_n = 1'b1, rrdy = 1'b0, tmt = 1'b1, roe = 1'b0, toe = 1'b0;
   logic [7:0]  rxb = 8'h00, pend = 8'h00, frame_cmd = 8'h00, rsp_base = 8'h11;
   logic [15:0] rdata_m = 16'hA5A5;
   logic        a_rd = 1'b0;
   logic [2:0]  a_addr = 3'd0;
   logic [15:0] a_wd = 16'h0;
   int shift_cnt = 0, run = 0, byte_idx = 0, cts_fail = 0, cyc = 0, rel_cyc = 0;
   bit cts_never = 0, last_poll = 0;
   int min_gap = 1000000, frames = 0, poll_frames = 0, accesses = 0, viol = 0;
   int done_cnt = 0, err_cnt = 0;
   logic [7:0] mosi[$];
   logic [7:0] rsp_log[$];
   logic [7:0] txq[16];

   assign bus.spi_rrdy  = rrdy;
   assign bus.spi_tmt   = tmt;
   assign bus.spi_rdata = rdata_m;

   // Register-port slave, byte shifter, radio responder and bus protocol monitor
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         ss_n = 1'b1; rrdy = 1'b0; tmt = 1'b1; roe = 1'b0; toe = 1'b0;
         shift_cnt = 0; run = 0; rdata_m = 16'hA5A5;
      end else begin
         rdata_m = 16'hA5A5;
         if (shift_cnt > 0) begin
            shift_cnt--;
            if (shift_cnt == 0) begin
               if (rrdy) roe = 1'b1;
               rrdy = 1'b1; tmt = 1'b1; rxb = pend;
            end
         end
         if (bus.spi_cs) begin
            run++;
            if (run == 1) begin
               a_rd = !bus.spi_rd_n; a_addr = bus.spi_addr; a_wd = bus.spi_wdata;
               if (bus.spi_rd_n == bus.spi_wr_n) viol++;
            end else if (a_rd != !bus.spi_rd_n || bus.spi_rd_n == bus.spi_wr_n ||
                         a_addr !== bus.spi_addr || a_wd !== bus.spi_wdata) viol++;
            if (run == 2) begin
               accesses++;
               if (a_rd) begin
                  if (a_addr == 3'd0) begin rdata_m = {8'h00, rxb}; rrdy = 1'b0; end
                  else viol++;
               end else if (a_addr == 3'd1) begin
                  if (shift_cnt > 0) toe = 1'b1;
                  mosi.push_back(a_wd[7:0]);
                  if (byte_idx == 0) begin
                     frame_cmd = a_wd[7:0]; pend = 8'h00;
                     if (a_wd[7:0] == 8'h44) poll_frames++;
                  end else if (frame_cmd == 8'h44 && byte_idx == 1) begin
                     if (cts_never || cts_fail > 0) begin
                        pend = 8'h00;
                        if (cts_fail > 0) cts_fail--;
                     end else pend = 8'hFF;
                  end else if (frame_cmd == 8'h44) pend = rsp_base + 8'(byte_idx - 2);
                  else pend = 8'h00;
                  byte_idx++;
                  shift_cnt = 8; tmt = 1'b0;
               end else if (a_addr == 3'd3) begin
                  if (a_wd == 16'h0400 && ss_n) begin
                     ss_n = 1'b0; frames++; byte_idx = 0;
                     if (last_poll && (cyc - rel_cyc) < min_gap) min_gap = cyc - rel_cyc;
                  end else if (a_wd == 16'h0000 && !ss_n) begin
                     ss_n = 1'b1; rel_cyc = cyc; last_poll = (frame_cmd == 8'h44);
                  end else viol++;
               end else viol++;
            end
         end else begin
            if (run != 0 && run != 2) viol++;
            run = 0;
            if (!bus.spi_rd_n || !bus.spi_wr_n) viol++;
         end
         if (rsp_valid) rsp_log.push_back(rsp_data);
         if (done) done_cnt++;
         if (err) err_cnt++;
      end
   end

   task automatic clear_log();
      mosi.delete(); rsp_log.delete();
      frames = 0; poll_frames = 0; accesses = 0; done_cnt = 0; err_cnt = 0;
      min_gap = 1000000; last_poll = 0;
   endtask

   // Pulses start and feeds n bytes from txq, optionally withholding tx_valid before one byte
   task automatic launch(input int n, input int rlen, input int stall_at, input int stall_cyc,
                         output int ss_hi);
      ss_hi = 0;
      @(negedge clk);
      tx_len = 5'(n); rsp_len = 5'(rlen); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_cyc; s++) begin
               @(negedge clk);
               if (ss_n) ss_hi++;
            end
         end
         tx_data = txq[i]; tx_valid = 1'b1;
         for (int t = 0; t < 2000 && !tx_ready; t++) @(negedge clk);
         @(negedge clk);
         tx_valid = 1'b0;
      end
   endtask

   // Waits for done/err; optionally fires a stray start with tx_len=0 while busy
   task automatic wait_end(input bit stray, output bit timed_out);
      int t;
      t = 0;
      while (done_cnt + err_cnt == 0 && t < 20000) begin
         @(negedge clk);
         if (stray && t == 20) begin tx_len = 5'd0; start = 1'b1; end
         else start = 1'b0;
         t++;
      end
      start = 1'b0;
      timed_out = (t >= 20000);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_ready, rsp_valid, busy, done, err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctl got %b want 00000", {tx_ready, rsp_valid, busy, done, err});
      end
      checks++;
      if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
      checks++;
      if ({bus.spi_cs, bus.spi_wr_n, bus.spi_rd_n} !== 3'b011) begin
         errors++; $display("FAIL reset_strobes got %b want 011", {bus.spi_cs, bus.spi_wr_n, bus.spi_rd_n});
      end
      checks++;
      if ({bus.spi_addr, bus.spi_wdata} !== 19'h0) begin
         errors++; $display("FAIL reset_addr_data got %h want 0", {bus.spi_addr, bus.spi_wdata});
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_part_info();
      int ss_hi;
      bit to;
      logic [7:0] exp;
      clear_log(); cts_fail = 0; cts_never = 0; rsp_base = 8'h11;
      txq[0] = 8'h01;
      launch(1, 8, -1, 0, ss_hi);
      wait_end(0, to);
      checks++;
      if (to) begin errors++; $display("FAIL part_timeout got timeout want done"); end
      checks++;
      if (mosi.size() != 11) begin errors++; $display("FAIL part_mosi_len got %0d want 11", mosi.size()); end
      for (int i = 0; i < 11 && i < mosi.size(); i++) begin
         exp = (i == 0) ? 8'h01 : (i == 1) ? 8'h44 : 8'hFF;
         checks++;
         if (mosi[i] !== exp) begin errors++; $display("FAIL part_mosi[%0d] got %h want %h", i, mosi[i], exp); end
      end
      checks++;
      if (rsp_log.size() != 8) begin errors++; $display("FAIL part_rsp_cnt got %0d want 8", rsp_log.size()); end
      for (int i = 0; i < 8 && i < rsp_log.size(); i++) begin
         exp = 8'h11 + 8'(i);
         checks++;
         if (rsp_log[i] !== exp) begin errors++; $display("FAIL part_rsp[%0d] got %h want %h", i, rsp_log[i], exp); end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
         errors++; $display("FAIL part_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
      checks++;
      if (frames != 2) begin errors++; $display("FAIL part_frames got %0d want 2", frames); end
      checks++;
      if (busy !== 1'b0 || ss_n !== 1'b1) begin
         errors++; $display("FAIL part_idle got busy=%b ss_n=%b want 0/1", busy, ss_n);
      end
   endtask

   task automatic test_cts_retry();
      int ss_hi;
      bit to;
      clear_log(); cts_fail = 3; cts_never = 0;
      txq[0] = 8'h15;
      launch(1, 0, -1, 0, ss_hi);
      wait_end(0, to);
      checks++;
      if (to || done_cnt != 1 || err_cnt != 0) begin
         errors++; $display("FAIL retry_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
      checks++;
      if (poll_frames != 4) begin errors++; $display("FAIL retry_polls got %0d want 4", poll_frames); end
      checks++;
      if (min_gap < POLL_GAP) begin errors++; $display("FAIL retry_gap got %0d want >=%0d", min_gap, POLL_GAP); end
      checks++;
      if (dut.poll_cnt != 4) begin errors++; $display("FAIL retry_poll_cnt got %0d want 4", dut.poll_cnt); end
      checks++;
      if (mosi.size() != 9 || rsp_log.size() != 0) begin
         errors++; $display("FAIL retry_bytes got mosi=%0d rsp=%0d want 9/0", mosi.size(), rsp_log.size());
      end
   endtask

   task automatic test_cts_timeout();
      int ss_hi;
      bit to;
      clear_log(); cts_never = 1;
      txq[0] = 8'h22;
      launch(1, 2, -1, 0, ss_hi);
      wait_end(0, to);
      checks++;
      if (poll_frames != POLL_MAX) begin errors++; $display("FAIL tmo_polls got %0d want %0d", poll_frames, POLL_MAX); end
      checks++;
      if (to || err_cnt != 1 || done_cnt != 0) begin
         errors++; $display("FAIL tmo_err got err=%0d done=%0d want 1/0", err_cnt, done_cnt);
      end
      checks++;
      if (ss_n !== 1'b1 || busy !== 1'b0 || rsp_log.size() != 0) begin
         errors++; $display("FAIL tmo_idle got ss_n=%b busy=%b rsp=%0d want 1/0/0", ss_n, busy, rsp_log.size());
      end
      cts_never = 0;
   endtask

   task automatic test_tx_stall();
      int ss_hi;
      bit to;
      clear_log();
      txq[0] = 8'h12; txq[1] = 8'h34; txq[2] = 8'h56;
      launch(3, 1, 1, 100, ss_hi);
      wait_end(0, to);
      checks++;
      if (ss_hi != 0) begin errors++; $display("FAIL stall_ss got %0d high cycles want 0", ss_hi); end
      checks++;
      if (mosi.size() != 6) begin errors++; $display("FAIL stall_mosi_len got %0d want 6", mosi.size()); end
      for (int i = 0; i < 3 && i < mosi.size(); i++) begin
         checks++;
         if (mosi[i] !== txq[i]) begin errors++; $display("FAIL stall_mosi[%0d] got %h want %h", i, mosi[i], txq[i]); end
      end
      checks++;
      if (roe !== 1'b0 || toe !== 1'b0) begin errors++; $display("FAIL stall_status got roe=%b toe=%b want 0/0", roe, toe); end
      checks++;
      if (to || done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_busy_start();
      int ss_hi;
      bit to;
      clear_log();
      txq[0] = 8'h01;
      launch(1, 1, -1, 0, ss_hi);
      wait_end(1, to);
      repeat (5) @(negedge clk);
      checks++;
      if (to || done_cnt != 1 || err_cnt != 0) begin
         errors++; $display("FAIL busy_start got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
      checks++;
      if (mosi.size() != 4 || frames != 2) begin
         errors++; $display("FAIL busy_frames got mosi=%0d frames=%0d want 4/2", mosi.size(), frames);
      end
   endtask

   task automatic test_len_zero();
      clear_log();
      @(negedge clk);
      tx_len = 5'd0; rsp_len = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_err got err=%b busy=%b want 1/0", err, busy);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (accesses != 0 || err_cnt != 1 || done_cnt != 0) begin
         errors++; $display("FAIL zero_bus got acc=%0d err=%0d done=%0d want 0/1/0", accesses, err_cnt, done_cnt);
      end
   endtask

   task automatic test_reset_mid_rsp();
      int ss_hi, t;
      bit to;
      clear_log();
      txq[0] = 8'h01;
      launch(1, 8, -1, 0, ss_hi);
      t = 0;
      while (rsp_log.size() < 3 && t < 5000) begin @(negedge clk); t++; end
      reset_n = 1'b0;
      #1;
      checks++;
      if (t >= 5000 || {bus.spi_cs, bus.spi_wr_n, bus.spi_rd_n, busy, rsp_valid, tx_ready, done, err} !== 8'b01100000) begin
         errors++;
         $display("FAIL mid_reset got %b want 01100000",
                  {bus.spi_cs, bus.spi_wr_n, bus.spi_rd_n, busy, rsp_valid, tx_ready, done, err});
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      clear_log();
      launch(1, 8, -1, 0, ss_hi);
      wait_end(0, to);
      checks++;
      if (to || done_cnt != 1 || mosi.size() != 11 || frames != 2) begin
         errors++; $display("FAIL post_reset got done=%0d mosi=%0d frames=%0d want 1/11/2", done_cnt, mosi.size(), frames);
      end
      checks++;
      if (rsp_log.size() != 8 || rsp_log[0] !== 8'h11 || rsp_log[rsp_log.size()-1] !== 8'h18) begin
         errors++; $display("FAIL post_reset_rsp got %0d bytes want 8 (11..18)", rsp_log.size());
      end
   endtask

   task automatic test_bus_protocol();
      checks++;
      if (viol != 0) begin errors++; $display("FAIL bus_protocol got %0d violations want 0", viol); end
      checks++;
      if (roe !== 1'b0 || toe !== 1'b0) begin errors++; $display("FAIL spi_status got roe=%b toe=%b want 0/0", roe, toe); end
   endtask

   initial begin
      test_reset();
      test_part_info();
      test_cts_retry();
      test_cts_timeout();
      test_tx_stall();
      test_busy_start();
      test_len_zero();
      test_reset_mid_rsp();
      test_bus_protocol();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
